// File: rtl/synth_param_controller.sv
// Mode/parameter controller: key events drive mode FSM, config registers and preset recall/store;
// 1-cycle key-to-output latency; updates held on upd_valid until upd_ready. Optional preset store: PRESET_STORE_EN.
module synth_param_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [2:0] key_row,
    input  logic [2:0] key_col,
    output logic       key_busy,
    output logic [2:0] mode,
    output logic [1:0] waveform_select,
    output logic [1:0] filter_select,
    output logic [2:0] filter_params,
    output logic [7:0] amp_envelope,
    output logic       upd_valid,
    output logic [2:0] upd_field,
    input  logic       upd_ready
);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_NOTIFY} state_t;

    localparam logic [23:0] CNT_LAST = 24'(TIMEOUT_CYCLES - 1);

    function automatic logic [14:0] builtin_preset(input logic [1:0] idx);
        case (idx)
            2'd0:    return {2'b00, 2'b00, 3'b000, 8'h00};
            2'd1:    return {2'b01, 2'b01, 3'b011, 8'h55};
            2'd2:    return {2'b10, 2'b10, 3'b101, 8'hAA};
            default: return {2'b10, 2'b11, 3'b111, 8'hFF};
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [2:0]  mode_q, mode_d;
    logic [1:0]  wave_q, wave_d;
    logic [1:0]  fsel_q, fsel_d;
    logic [2:0]  fpar_q, fpar_d;
    logic [7:0]  env_q, env_d;
    logic        upd_valid_q, upd_valid_d;
    logic [2:0]  upd_field_q, upd_field_d;

    logic        key_ok;
    logic [1:0]  col_idx;
    logic [1:0]  lvl;
    logic [14:0] preset_rd;
    logic        apply;
    logic        hit;
    logic [2:0]  field;

    assign key_ok  = key_valid && (state_q != S_NOTIFY) &&
                     (key_row >= 3'd1) && (key_row <= 3'd4) &&
                     (key_col >= 3'd1) && (key_col <= 3'd4);
    assign col_idx = 2'(key_col - 3'd1);
    assign lvl     = 2'(3'd4 - key_row);

`ifdef PRESET_STORE_EN
    logic [14:0] preset_q [4];
    logic        preset_we;

    assign preset_rd = preset_q[col_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) preset_q[i] <= builtin_preset(2'(i));
        end else if (preset_we) begin
            preset_q[col_idx] <= {wave_q, fsel_q, fpar_q, env_q};
        end
    end
`else
    assign preset_rd = builtin_preset(col_idx);
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        wave_d      = wave_q;
        fsel_d      = fsel_q;
        fpar_d      = fpar_q;
        env_d       = env_q;
        upd_valid_d = upd_valid_q;
        upd_field_d = upd_field_q;
        apply       = 1'b0;
        hit         = 1'b0;
        field       = 3'd0;
`ifdef PRESET_STORE_EN
        preset_we   = 1'b0;
`endif
        if (state_q == S_NOTIFY) begin
            if (upd_ready) begin
                upd_valid_d = 1'b0;
                state_d     = S_ARMED;
                cnt_d       = '0;
            end
        end else begin
            if (key_ok && key_row == 3'd4) begin
                mode_d  = key_col;
                state_d = S_ARMED;
                cnt_d   = '0;
                hit     = 1'b1;
            end else if (key_ok && state_q == S_ARMED) begin
                case (mode_q)
                    3'd1: if (key_col != 3'd4) begin
                        wave_d = col_idx;
                        apply  = 1'b1;
                        field  = 3'd0;
                    end
                    3'd2: if (key_row == 3'd3) begin
                        fsel_d = col_idx;
                        apply  = 1'b1;
                        field  = 3'd1;
                    end else begin
                        fpar_d = {col_idx, key_row == 3'd2};
                        apply  = 1'b1;
                        field  = 3'd2;
                    end
                    3'd3: begin
                        case (col_idx)
                            2'd0:    env_d[1:0] = lvl;
                            2'd1:    env_d[3:2] = lvl;
                            2'd2:    env_d[5:4] = lvl;
                            default: env_d[7:6] = lvl;
                        endcase
                        apply = 1'b1;
                        field = 3'd3;
                    end
                    3'd4: if (key_row == 3'd1) begin
                        {wave_d, fsel_d, fpar_d, env_d} = preset_rd;
                        apply = 1'b1;
                        field = 3'd4;
`ifdef PRESET_STORE_EN
                    end else if (key_row == 3'd2) begin
                        preset_we = 1'b1;
                        cnt_d     = '0;
                        hit       = 1'b1;
`endif
                    end
                    default: ;
                endcase
            end
            if (apply) begin
                upd_valid_d = 1'b1;
                upd_field_d = field;
                state_d     = S_NOTIFY;
                hit         = 1'b1;
            end
            // Keys with no effect leave the idle timer running.
            if (!hit && state_q == S_ARMED) begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    mode_d  = 3'd0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mode_q      <= '0;
            wave_q      <= '0;
            fsel_q      <= '0;
            fpar_q      <= '0;
            env_q       <= '0;
            upd_valid_q <= 1'b0;
            upd_field_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            wave_q      <= wave_d;
            fsel_q      <= fsel_d;
            fpar_q      <= fpar_d;
            env_q       <= env_d;
            upd_valid_q <= upd_valid_d;
            upd_field_q <= upd_field_d;
        end
    end

    assign key_busy        = (state_q == S_NOTIFY);
    assign mode            = mode_q;
    assign waveform_select = wave_q;
    assign filter_select   = fsel_q;
    assign filter_params   = fpar_q;
    assign amp_envelope    = env_q;
    assign upd_valid       = upd_valid_q;
    assign upd_field       = upd_field_q;

endmodule

// File: tb/tb_synth_param_controller.sv
// Bench for synth_param_controller: rule-level model compared every cycle plus literal checks.
module tb_synth_param_controller;

    localparam int TO = 8;

    logic       clk;
    logic       reset;
    logic       key_valid;
    logic [2:0] key_row;
    logic [2:0] key_col;
    logic       key_busy;
    logic [2:0] mode;
    logic [1:0] waveform_select;
    logic [1:0] filter_select;
    logic [2:0] filter_params;
    logic [7:0] amp_envelope;
    logic       upd_valid;
    logic [2:0] upd_field;
    logic       upd_ready;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;
    int uv_cnt;

    synth_param_controller #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .key_valid(key_valid), .key_row(key_row), .key_col(key_col),
        .key_busy(key_busy), .mode(mode),
        .waveform_select(waveform_select), .filter_select(filter_select),
        .filter_params(filter_params), .amp_envelope(amp_envelope),
        .upd_valid(upd_valid), .upd_field(upd_field), .upd_ready(upd_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // st: 0 idle, 1 armed, 2 notify
    typedef struct packed {
        logic [1:0]        st;
        logic [23:0]       cnt;
        logic [2:0]        mode;
        logic [1:0]        wave;
        logic [1:0]        fsel;
        logic [2:0]        fpar;
        logic [7:0]        env;
        logic              uv;
        logic [2:0]        uf;
        logic [3:0][14:0]  pre;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t mdl_reset();
        mdl_t n;
        n = '0;
        n.pre[0] = 15'b00_00_000_00000000;
        n.pre[1] = 15'b01_01_011_01010101;
        n.pre[2] = 15'b10_10_101_10101010;
        n.pre[3] = 15'b10_11_111_11111111;
        return n;
    endfunction

    function automatic mdl_t mdl_next(mdl_t c, logic kv, logic [2:0] r, logic [2:0] k, logic rdy);
        mdl_t n;
        int ri, ci, fld;
        bit acc, eff;
        n   = c;
        ri  = int'(r);
        ci  = int'(k);
        fld = -1;
        eff = 0;
        if (c.st == 2'd2) begin
            if (rdy) begin
                n.uv  = 1'b0;
                n.st  = 2'd1;
                n.cnt = '0;
            end
            return n;
        end
        acc = kv && ri >= 1 && ri <= 4 && ci >= 1 && ci <= 4;
        if (acc && ri == 4) begin
            n.mode = k;
            n.st   = 2'd1;
            n.cnt  = '0;
            eff    = 1;
        end else if (acc && c.st == 2'd1) begin
            if (c.mode == 3'd1 && ci <= 3) begin
                n.wave = 2'(ci - 1);
                fld = 0;
            end else if (c.mode == 3'd2) begin
                if (ri == 3) begin
                    n.fsel = 2'(ci - 1);
                    fld = 1;
                end else begin
                    n.fpar = 3'((ci - 1) * 2 + (ri == 2 ? 1 : 0));
                    fld = 2;
                end
            end else if (c.mode == 3'd3) begin
                n.env[2*ci-2 +: 2] = 2'(4 - ri);
                fld = 3;
            end else if (c.mode == 3'd4 && ri == 1) begin
                {n.wave, n.fsel, n.fpar, n.env} = c.pre[ci-1];
                fld = 4;
            end
`ifdef PRESET_STORE_EN
            else if (c.mode == 3'd4 && ri == 2) begin
                n.pre[ci-1] = {c.wave, c.fsel, c.fpar, c.env};
                n.cnt = '0;
                eff = 1;
            end
`endif
        end
        if (fld >= 0) begin
            n.uv = 1'b1;
            n.uf = 3'(fld);
            n.st = 2'd2;
            eff  = 1;
        end
        if (!eff && c.st == 2'd1) begin
            if (int'(c.cnt) + 1 >= TO) begin
                n.st   = 2'd0;
                n.mode = 3'd0;
                n.cnt  = '0;
            end else begin
                n.cnt = c.cnt + 24'd1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= mdl_reset();
        else       m <= mdl_next(m, key_valid, key_row, key_col, upd_ready);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_mode",  32'(mode),            32'(m.mode));
            check("cyc_wave",  32'(waveform_select), 32'(m.wave));
            check("cyc_fsel",  32'(filter_select),   32'(m.fsel));
            check("cyc_fpar",  32'(filter_params),   32'(m.fpar));
            check("cyc_env",   32'(amp_envelope),    32'(m.env));
            check("cyc_uv",    32'(upd_valid),       32'(m.uv));
            check("cyc_uf",    32'(upd_field),       32'(m.uf));
            check("cyc_busy",  32'(key_busy),        32'(m.st == 2'd2));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_key(input logic [2:0] r, input logic [2:0] c);
        key_valid = 1'b1;
        key_row   = r;
        key_col   = c;
        tick();
        key_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        key_valid = 1'b0;
        key_row   = 3'd0;
        key_col   = 3'd0;
        upd_ready = 1'b1;
        #1 reset = 1'b1;
        #1 chk_en = 1'b1;
        check("rst_mode", 32'(mode), 32'd0);
        check("rst_uv",   32'(upd_valid), 32'd0);
        check("rst_busy", 32'(key_busy), 32'd0);
        check("rst_env",  32'(amp_envelope), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        tick();

        // Wave mode, sawtooth.
        send_key(3'd4, 3'd1);
        send_key(3'd1, 3'd2);
        check("t1_mode", 32'(mode), 32'd1);
        check("t1_wave", 32'(waveform_select), 32'h1);
        check("t1_uv",   32'(upd_valid), 32'd1);
        check("t1_uf",   32'(upd_field), 32'd0);
        tick();
        check("t1_uv_drop", 32'(upd_valid), 32'd0);
        check("t1_mode_kept", 32'(mode), 32'd1);

        // Envelope with 5-cycle stall; key during stall dropped.
        send_key(3'd4, 3'd3);
        upd_ready = 1'b0;
        send_key(3'd2, 3'd4);
        uv_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            uv_cnt += int'(upd_valid);
            if (i == 2) begin
                check("t2_busy", 32'(key_busy), 32'd1);
                key_valid = 1'b1; key_row = 3'd1; key_col = 3'd1;
            end else begin
                key_valid = 1'b0;
            end
            tick();
        end
        key_valid = 1'b0;
        upd_ready = 1'b1;
        uv_cnt += int'(upd_valid);
        tick();
        for (int i = 0; i < 3; i++) begin
            uv_cnt += int'(upd_valid);
            tick();
        end
        check("t2_uv_cycles", 32'(uv_cnt), 32'd6);
        check("t2_env", 32'(amp_envelope), 32'h80);

        // Filter type then cutoff.
        send_key(3'd4, 3'd2);
        send_key(3'd3, 3'd3);
        check("t3_fsel", 32'(filter_select), 32'h2);
        check("t3_uf1",  32'(upd_field), 32'd1);
        tick();
        send_key(3'd2, 3'd2);
        check("t3_fpar", 32'(filter_params), 32'h3);
        check("t3_uf2",  32'(upd_field), 32'd2);
        tick();

        // Preset recall of slot 2.
        send_key(3'd4, 3'd4);
        send_key(3'd1, 3'd3);
        check("t4_all", 32'({waveform_select, filter_select, filter_params, amp_envelope}),
              32'({2'b10, 2'b10, 3'b101, 8'hAA}));
        check("t4_uf", 32'(upd_field), 32'd4);
        tick();
`ifdef PRESET_STORE_EN
        send_key(3'd4, 3'd1);
        send_key(3'd1, 3'd1);
        tick();
        send_key(3'd4, 3'd4);
        send_key(3'd2, 3'd1);
        check("t4_store_nouv", 32'(upd_valid), 32'd0);
        send_key(3'd1, 3'd1);
        check("t4_recall", 32'({waveform_select, filter_select, filter_params, amp_envelope}),
              32'({2'b00, 2'b10, 3'b101, 8'hAA}));
        tick();
`else
        send_key(3'd4, 3'd4);
        send_key(3'd1, 3'd1);
        check("t4_recall", 32'({waveform_select, filter_select, filter_params, amp_envelope}), 32'd0);
        tick();
`endif

        // Timeout after 8 idle cycles.
        send_key(3'd4, 3'd1);
        for (int i = 0; i < TO - 1; i++) tick();
        check("t5_mode_before", 32'(mode), 32'd1);
        tick();
        check("t5_mode_expired", 32'(mode), 32'd0);
        send_key(3'd1, 3'd2);
        check("t5_ignored_wave", 32'(waveform_select), 32'd0);
        check("t5_ignored_uv",   32'(upd_valid), 32'd0);
        send_key(3'd4, 3'd1);
        for (int i = 0; i < TO - 1; i++) tick();
        send_key(3'd1, 3'd3);
        check("t5_expiry_key_mode", 32'(mode), 32'd1);
        check("t5_expiry_key_wave", 32'(waveform_select), 32'h2);
        tick();

        // Reset during NOTIFY.
        send_key(3'd4, 3'd3);
        upd_ready = 1'b0;
        send_key(3'd1, 3'd1);
        check("t6_uv_pre", 32'(upd_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t6_async_uv",   32'(upd_valid), 32'd0);
        check("t6_async_mode", 32'(mode), 32'd0);
        check("t6_async_env",  32'(amp_envelope), 32'd0);
        check("t6_async_busy", 32'(key_busy), 32'd0);
        check("t6_async_wave", 32'(waveform_select), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        upd_ready = 1'b1;
        tick(); tick(); tick();
        check("t6_no_replay", 32'(upd_valid), 32'd0);
        send_key(3'd4, 3'd4);
        send_key(3'd1, 3'd1);
        check("t6_preset_restored", 32'({waveform_select, filter_select, filter_params, amp_envelope}), 32'd0);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
